// File: rtl/mmio_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mmio_dispatch (and package mmio_dispatch_pkg)
// Brief    : Routes one PSL MMIO request at a time to the AFU descriptor or a
//            problem-state region, waits for the target ack (with timeout)
//            and returns exactly one MMIO ack. Optional feature macro:
//            MMIO_PARITY_CHECK_EN (address/write-data parity checking).
// Revision : 1.0 - initial release
// ============================================================================

package mmio_dispatch_pkg;
    typedef struct packed {
        logic        valid;
        logic        cfg;
        logic        read;
        logic [0:23] address;
        logic        address_parity;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceInput;

    typedef struct packed {
        logic        ack;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceOutput;
endpackage

module mmio_dispatch
    import mmio_dispatch_pkg::*;
#(
    parameter int NUM_TARGETS  = 4,
    parameter int REGION_SHIFT = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  MMIOInterfaceInput         mmio_in,
    output MMIOInterfaceOutput        mmio_out,
    output logic [NUM_TARGETS-1:0]    tgt_req,
    output logic                      tgt_read,
    output logic [23:0]               tgt_address,
    output logic [63:0]               tgt_wdata,
    input  logic [NUM_TARGETS-1:0]    tgt_ack,
    input  logic [NUM_TARGETS*64-1:0] tgt_rdata,
    output logic                      busy,
    output logic                      timeout_error,
    output logic                      parity_error
);

    // A single problem-state region still needs a one-bit index field.
    localparam int c_IDX_W = (NUM_TARGETS > 2) ? $clog2(NUM_TARGETS - 1) : 1;
    localparam int c_SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [c_IDX_W:0]       c_NUM_REGIONS = (c_IDX_W + 1)'(NUM_TARGETS - 1);
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST    = c_CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_TARGETS-1:0] c_REQ_ONE     = NUM_TARGETS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SEL_W-1:0]   r_sel;
    logic                 r_mapped;
    logic [63:0]          r_resp;
    logic                 w_resp_ld;
    logic [63:0]          w_resp_val;
    logic                 w_par_bad;

    logic [23:0]          w_in_addr;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_in_mapped;
    logic [c_SEL_W-1:0]   w_in_sel;
    logic                 w_sel_ack;
    logic [63:0]          w_sel_rdata;

    // Numeric view of the big-endian address so region bits count from the LSB.
    assign w_in_addr   = mmio_in.address;
    assign w_idx       = w_in_addr[REGION_SHIFT +: c_IDX_W];
    assign w_in_mapped = mmio_in.cfg || ({1'b0, w_idx} < c_NUM_REGIONS);
    assign w_in_sel    = mmio_in.cfg ? '0 : (c_SEL_W'(w_idx) + c_SEL_W'(1));

    assign w_sel_ack   = tgt_ack[r_sel];
    assign w_sel_rdata = tgt_rdata[r_sel*64 +: 64];

`ifdef MMIO_PARITY_CHECK_EN
    logic r_addr_par;
    logic r_data_par;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_addr_par <= 1'b0;
            r_data_par <= 1'b0;
        end else if (r_state == S_IDLE && mmio_in.valid) begin
            r_addr_par <= mmio_in.address_parity;
            r_data_par <= mmio_in.data_parity;
        end
    end

    assign w_par_bad = (r_addr_par != ~^tgt_address) ||
                       (!tgt_read && (r_data_par != ~^tgt_wdata));
`else
    logic w_unused_parity;
    assign w_unused_parity = mmio_in.address_parity ^ mmio_in.data_parity;
    assign w_par_bad       = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_resp_ld     = 1'b0;
        w_resp_val    = '0;
        tgt_req       = '0;
        timeout_error = 1'b0;
        parity_error  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mmio_in.valid) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_par_bad) begin
                    parity_error = 1'b1;
                    w_resp_ld    = 1'b1;
                    w_resp_val   = '1;
                    w_state_nxt  = S_RESPOND;
                end else if (!r_mapped) begin
                    w_resp_ld   = 1'b1;
                    w_state_nxt = S_RESPOND;
                end else begin
                    tgt_req     = c_REQ_ONE << r_sel;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A target ack on the final counted cycle beats the timeout.
                if (w_sel_ack) begin
                    w_resp_ld   = 1'b1;
                    w_resp_val  = tgt_read ? w_sel_rdata : 64'd0;
                    w_state_nxt = S_RESPOND;
                end else if (r_cnt == c_CNT_LAST) begin
                    timeout_error = 1'b1;
                    w_resp_ld     = 1'b1;
                    w_resp_val    = '1;
                    w_state_nxt   = S_RESPOND;
                end
            end
            S_RESPOND: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_mapped    <= 1'b0;
            r_resp      <= '0;
            tgt_read    <= 1'b0;
            tgt_address <= '0;
            tgt_wdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && mmio_in.valid) begin
                tgt_read    <= mmio_in.read;
                tgt_address <= mmio_in.address;
                tgt_wdata   <= mmio_in.data;
                r_sel       <= w_in_sel;
                r_mapped    <= w_in_mapped;
            end
            if (r_state == S_ISSUE)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_resp_ld)
                r_resp <= w_resp_val;
        end
    end

    logic w_ack;
    assign w_ack = (r_state == S_RESPOND);
    assign busy  = (r_state != S_IDLE);

    always_comb begin
        mmio_out             = '0;
        mmio_out.ack         = w_ack;
        mmio_out.data        = w_ack ? r_resp : 64'd0;
        mmio_out.data_parity = ~^(w_ack ? r_resp : 64'd0);
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_dispatch
// Brief    : Scoreboard bench for mmio_dispatch with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_dispatch;
    import mmio_dispatch_pkg::*;

    localparam int NT = 4;
    localparam int RS = 16;
    localparam int TO = 255;
    localparam int IW = $clog2(NT - 1);
`ifdef MMIO_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        int          ack_cyc;
        int          to_cyc;
        int          par_cyc;
    } exp_t;

    typedef struct {
        logic [NT-1:0] req;
        int            cyc;
        logic [23:0]   addr;
        logic [63:0]   wdata;
        logic          rd;
    } req_t;

    logic               clock   = 1'b0;
    logic               reset_n = 1'b0;
    MMIOInterfaceInput  mmio_in;
    MMIOInterfaceOutput mmio_out;
    logic [NT-1:0]      tgt_req;
    logic               tgt_read;
    logic [23:0]        tgt_address;
    logic [63:0]        tgt_wdata;
    logic [NT-1:0]      tgt_ack = '0;
    logic [NT*64-1:0]   tgt_rdata;
    logic               busy;
    logic               timeout_error;
    logic               parity_error;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   ack_tgt     = -1;
    int   ack_cycle   = -1;
    bit   noise_en    = 1'b0;
    int   to_seen     = -1;
    int   par_seen    = -1;
    exp_t sb[$];
    req_t rq[$];

    mmio_dispatch #(.NUM_TARGETS(NT), .REGION_SHIFT(RS), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mmio_in       (mmio_in),
        .mmio_out      (mmio_out),
        .tgt_req       (tgt_req),
        .tgt_read      (tgt_read),
        .tgt_address   (tgt_address),
        .tgt_wdata     (tgt_wdata),
        .tgt_ack       (tgt_ack),
        .tgt_rdata     (tgt_rdata),
        .busy          (busy),
        .timeout_error (timeout_error),
        .parity_error  (parity_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Target model: selected target pulses once at its scheduled cycle,
    // other targets optionally toggle randomly and must be ignored.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NT; i++) begin
            if (i == ack_tgt) tgt_ack[i] = (cyc == ack_cycle);
            else              tgt_ack[i] = noise_en ? 1'($urandom % 2) : 1'b0;
        end
    end

    // Monitor
    always @(negedge clock) begin
        exp_t        e;
        req_t        r;
        logic [63:0] d;
        if (!reset_n) begin
            to_seen  = -1;
            par_seen = -1;
        end else begin
            if (timeout_error) to_seen = cyc;
            if (parity_error)  par_seen = cyc;
            if (tgt_req != '0) begin
                if (rq.size() == 0) check("unexpected_req", 64'(tgt_req), 64'd0);
                else begin
                    r = rq.pop_front();
                    check("req_onehot", 64'(tgt_req), 64'(r.req));
                    check("req_cycle", 64'(cyc), 64'(r.cyc));
                    check("req_addr", 64'(tgt_address), 64'(r.addr));
                    check("req_wdata", tgt_wdata, r.wdata);
                    check("req_read", 64'(tgt_read), 64'(r.rd));
                end
            end
            if (mmio_out.ack) begin
                if (sb.size() == 0) check("unexpected_ack", 64'(mmio_out.ack), 64'd0);
                else begin
                    e = sb.pop_front();
                    d = mmio_out.data;
                    check("ack_data", d, e.data);
                    check("ack_parity", 64'(mmio_out.data_parity),
                          64'($countones(e.data) % 2 == 0));
                    check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
                    check("timeout_err_cycle", 64'(to_seen), 64'(e.to_cyc));
                    check("parity_err_cycle", 64'(par_seen), 64'(e.par_cyc));
                    to_seen  = -1;
                    par_seen = -1;
                end
            end else if (mmio_out.data != '0) begin
                d = mmio_out.data;
                check("data_without_ack", d, 64'd0);
            end
        end
    end

    task automatic rand_rdata();
        for (int i = 0; i < NT; i++) tgt_rdata[i*64 +: 64] = {$urandom, $urandom};
    endtask

    // dly: cycles from tgt_req to target ack; -1 means the target never acks.
    // bad: 0 = good parity, 1 = address parity flipped, 2 = data parity flipped.
    task automatic issue(input bit cfg, input bit rd, input logic [23:0] addr,
                         input logic [63:0] wd, input int dly, input int bad);
        int   idx, tgt, c0;
        bit   perr;
        exp_t e;
        req_t r;
        idx  = (int'(addr) >> RS) % (1 << IW);
        tgt  = cfg ? 0 : ((idx < NT - 1) ? idx + 1 : -1);
        perr = PAR_EN && (bad == 1 || (bad == 2 && !rd));
        c0   = cyc;
        e.to_cyc  = -1;
        e.par_cyc = -1;
        if (perr) begin
            e.data    = '1;
            e.ack_cyc = c0 + 2;
            e.par_cyc = c0 + 1;
        end else if (tgt < 0) begin
            e.data    = '0;
            e.ack_cyc = c0 + 2;
        end else begin
            r.req   = NT'(1) << tgt;
            r.cyc   = c0 + 1;
            r.addr  = addr;
            r.wdata = wd;
            r.rd    = rd;
            rq.push_back(r);
            if (dly >= 1 && dly <= TO) begin
                e.data    = rd ? tgt_rdata[tgt*64 +: 64] : 64'd0;
                e.ack_cyc = c0 + 2 + dly;
            end else begin
                e.data    = '1;
                e.ack_cyc = c0 + 2 + TO;
                e.to_cyc  = c0 + 1 + TO;
            end
        end
        sb.push_back(e);
        ack_tgt   = (perr || tgt < 0) ? -1 : tgt;
        ack_cycle = (dly >= 1) ? c0 + 1 + dly : -1;
        mmio_in.valid          = 1'b1;
        mmio_in.cfg            = cfg;
        mmio_in.read           = rd;
        mmio_in.address        = addr;
        mmio_in.data           = wd;
        mmio_in.address_parity = (~^addr) ^ (bad == 1);
        mmio_in.data_parity    = (~^wd) ^ (bad == 2);
        @(posedge clock); #1;
        mmio_in.valid = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 2 * TO + 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (busy) check("done_bound", 64'(busy), 64'd0);
    endtask

    task automatic txn(input bit cfg, input bit rd, input logic [23:0] addr,
                       input logic [63:0] wd, input int dly, input int bad);
        issue(cfg, rd, addr, wd, dly, bad);
        wait_done();
    endtask

    initial begin
        mmio_in   = '0;
        tgt_rdata = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(mmio_out.ack), 64'd0);
        check("rst_req", 64'(tgt_req), 64'd0);
        check("rst_addr", 64'(tgt_address), 64'd0);
        check("rst_wdata", tgt_wdata, 64'd0);
        check("rst_flags", 64'({timeout_error, parity_error, tgt_read}), 64'd0);

        // Descriptor read, minimum latency
        rand_rdata();
        tgt_rdata[63:0] = 64'h0000_0001_0001_0010;
        txn(1'b1, 1'b1, 24'h000000, 64'd0, 1, 0);
        // Problem-state write to region 2 (target 3)
        rand_rdata();
        txn(1'b0, 1'b0, 24'h020000, 64'h0000_0000_DEAD_BEEF, 5, 0);
        // Unmapped region
        rand_rdata();
        txn(1'b0, 1'b1, 24'h030000, 64'd0, 3, 0);
        // Timeout, then ack exactly on the timeout cycle
        rand_rdata();
        txn(1'b0, 1'b1, 24'h010000, 64'd0, -1, 0);
        rand_rdata();
        txn(1'b0, 1'b1, 24'h000000, 64'd0, TO, 0);

        // Second valid while waiting must be ignored
        rand_rdata();
        issue(1'b0, 1'b1, 24'h010000, 64'h1234, 8, 0);
        repeat (3) begin @(posedge clock); #1; end
        mmio_in.valid   = 1'b1;
        mmio_in.cfg     = 1'b1;
        mmio_in.address = 24'h000000;
        repeat (2) begin @(posedge clock); #1; end
        mmio_in.valid = 1'b0;
        wait_done();
        check("addr_hold", 64'(tgt_address), 64'h010000);

        // Reset in WAIT drops the transaction
        rand_rdata();
        issue(1'b0, 1'b0, 24'h020000, 64'h55AA, -1, 0);
        repeat (4) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        sb.delete();
        rq.delete();
        ack_tgt = -1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("rst_wait_busy", 64'(busy), 64'd0);
        check("rst_wait_addr", 64'(tgt_address), 64'd0);
        check("rst_wait_wdata", tgt_wdata, 64'd0);
        check("rst_wait_ack", 64'(mmio_out.ack), 64'd0);
        repeat (3) begin @(posedge clock); #1; end
        rand_rdata();
        txn(1'b0, 1'b1, 24'h000000, 64'd0, 2, 0);

`ifdef MMIO_PARITY_CHECK_EN
        rand_rdata();
        txn(1'b0, 1'b1, 24'h010000, 64'd0, 2, 1);
        rand_rdata();
        txn(1'b0, 1'b0, 24'h000000, 64'hF0F0, 2, 2);
`endif

        // Randomized traffic with ack noise on other targets
        noise_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int dly;
            dly = ($urandom % 20 == 0) ? -1 : 1 + int'($urandom % 10);
            rand_rdata();
            txn(1'($urandom % 4 == 0), 1'($urandom % 2), 24'($urandom),
                {$urandom, $urandom}, dly, int'($urandom % 3));
        end
        noise_en = 1'b0;
        repeat (4) begin @(posedge clock); #1; end

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("rq_empty", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
